// File: rtl/stepper_move_engine_pkg.sv
// Shared move codes, face indices, FSM states and helpers
// for the cube-robot stepper move engine.
package rbot_pkg;

    localparam int R    = 2;
    localparam int Ri   = 3;
    localparam int L    = 4;
    localparam int Li   = 5;
    localparam int U    = 6;
    localparam int Ui   = 7;
    localparam int F    = 8;
    localparam int Fi   = 9;
    localparam int B    = 10;
    localparam int Bi   = 11;
    localparam int D    = 12;
    localparam int Di   = 13;
    localparam int NULL = 15;

    localparam int RIGHT = 0;
    localparam int LEFT  = 1;
    localparam int UP    = 2;
    localparam int FRONT = 3;
    localparam int BACK  = 4;
    localparam int DOWN  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STEP_HI,
        ST_STEP_LO,
        ST_SETTLE,
        ST_DONE
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/stepper_move_engine_cycle_timer.sv
// Loadable down-counter; expire marks the last cycle
// of a phase while counting is enabled.
module cycle_timer #(
    parameter int TW = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          count_en,
    output logic          expire
);

    logic [TW-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count_en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = count_en && (count == '0);

endmodule

// File: rtl/stepper_move_engine.sv
// Executes one cube move: DIR setup, N step pulses,
// settle dwell, with abort and illegal-code reporting.
module stepper_move_engine #(
    parameter int NUM_MOTORS    = 6,
    parameter int MOVE_W        = 4,
    parameter int QUARTER_STEPS = 50,
    parameter int STEP_HALF     = 500000,
    parameter int DIR_SETUP     = 100,
    parameter int SETTLE        = 1000000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [MOVE_W-1:0]     move_code,
    input  logic                  move_half,
    input  logic                  move_valid,
    output logic                  move_ready,
    input  logic                  abort,
    output logic                  move_done,
    output logic                  move_err,
    output logic                  aborted,
    output logic                  dir_pin,
    output logic                  step_pin,
    output logic [NUM_MOTORS-1:0] en_pins
);

    import rbot_pkg::*;

    localparam int FW = MOVE_W - 1;
    localparam int CW = $clog2(2 * QUARTER_STEPS + 1);
    localparam int TW = $clog2(max3(STEP_HALF, DIR_SETUP, SETTLE) + 1);

    state_t        state;
    logic [CW-1:0] step_cnt;
    logic [CW-1:0] step_target;
    logic          abort_q;

    logic          accept;
    logic [FW-1:0] face_field;
    logic [FW-1:0] face;
    logic          is_null;
    logic          is_legal;
    logic          abort_hit;
    logic [CW-1:0] cnt_inc;
    logic          more_steps;

    logic          t_load;
    logic          t_run;
    logic          t_exp;
    logic [TW-1:0] t_val;

    assign accept     = move_valid & move_ready;
    assign face_field = move_code[MOVE_W-1:1];
    assign face       = face_field - 1'b1;
    assign is_null    = &move_code;
    assign is_legal   = !is_null && face_field != '0
                        && face_field <= FW'(NUM_MOTORS);
    assign abort_hit  = abort_q | abort;
    assign cnt_inc    = step_cnt + 1'b1;
    assign more_steps = (cnt_inc < step_target) && !abort_hit;

    assign t_run = (state == ST_SETUP) || (state == ST_STEP_HI)
                   || (state == ST_STEP_LO) || (state == ST_SETTLE);

    // Timer is reloaded on the same edge that enters the next phase.
    always_comb begin
        t_load = 1'b0;
        t_val  = '0;
        case (state)
            ST_IDLE: begin
                if (accept && is_legal) begin
                    t_load = 1'b1;
                    t_val  = TW'(DIR_SETUP - 1);
                end
            end
            ST_SETUP: begin
                if (t_exp) begin
                    t_load = 1'b1;
                    t_val  = abort_hit ? TW'(SETTLE - 1)
                                       : TW'(STEP_HALF - 1);
                end
            end
            ST_STEP_HI: begin
                if (t_exp) begin
                    t_load = 1'b1;
                    t_val  = TW'(STEP_HALF - 1);
                end
            end
            ST_STEP_LO: begin
                if (t_exp) begin
                    t_load = 1'b1;
                    t_val  = more_steps ? TW'(STEP_HALF - 1)
                                        : TW'(SETTLE - 1);
                end
            end
            default: begin
                t_load = 1'b0;
            end
        endcase
    end

    cycle_timer #(
        .TW(TW)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (t_load),
        .load_val(t_val),
        .count_en(t_run),
        .expire  (t_exp)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            step_cnt    <= '0;
            step_target <= '0;
            abort_q     <= 1'b0;
            move_ready  <= 1'b0;
            move_done   <= 1'b0;
            move_err    <= 1'b0;
            aborted     <= 1'b0;
            dir_pin     <= 1'b0;
            step_pin    <= 1'b0;
            en_pins     <= '0;
        end else begin
            move_done <= 1'b0;
            move_err  <= 1'b0;
            aborted   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        move_ready <= 1'b0;
                        step_cnt   <= '0;
                        abort_q    <= 1'b0;
                        if (is_null) begin
                            state     <= ST_DONE;
                            move_done <= 1'b1;
                        end else if (is_legal) begin
                            state       <= ST_SETUP;
                            en_pins     <= NUM_MOTORS'(1) << face;
                            dir_pin     <= move_code[0];
                            step_target <= move_half
                                ? CW'(2 * QUARTER_STEPS)
                                : CW'(QUARTER_STEPS);
                        end else begin
                            state    <= ST_DONE;
                            move_err <= 1'b1;
                        end
                    end else begin
                        move_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (abort) abort_q <= 1'b1;
                    if (t_exp) begin
                        if (abort_hit) begin
                            state <= ST_SETTLE;
                        end else begin
                            state    <= ST_STEP_HI;
                            step_pin <= 1'b1;
                        end
                    end
                end
                ST_STEP_HI: begin
                    if (abort) abort_q <= 1'b1;
                    if (t_exp) begin
                        state    <= ST_STEP_LO;
                        step_pin <= 1'b0;
                    end
                end
                ST_STEP_LO: begin
                    if (abort) abort_q <= 1'b1;
                    if (t_exp) begin
                        step_cnt <= cnt_inc;
                        if (more_steps) begin
                            state    <= ST_STEP_HI;
                            step_pin <= 1'b1;
                        end else begin
                            state <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (t_exp) begin
                        state     <= ST_DONE;
                        move_done <= 1'b1;
                        aborted   <= abort_q;
                        en_pins   <= '0;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    move_ready <= 1'b1;
                    abort_q    <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_move_engine.sv
// Scoreboard bench: driver pushes expected done/err events,
// a monitor pops and checks them when the engine pulses.
module tb_stepper_move_engine;

    import rbot_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] move_code;
    logic       move_half;
    logic       move_valid;
    logic       move_ready;
    logic       abort;
    logic       move_done;
    logic       move_err;
    logic       aborted;
    logic       dir_pin;
    logic       step_pin;
    logic [5:0] en_pins;

    typedef struct {
        bit is_err;
        int cyc;
        bit ab;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   rises = 0;
    int   first_rise = -1;
    int   hi_len = 0;
    bit   step_prev = 1'b0;
    bit   skip_pw = 1'b0;
    int   c0;

    stepper_move_engine #(
        .NUM_MOTORS   (6),
        .MOVE_W       (4),
        .QUARTER_STEPS(4),
        .STEP_HALF    (3),
        .DIR_SETUP    (2),
        .SETTLE       (5)
    ) dut (
        .clock     (clk),
        .reset_n   (reset_n),
        .move_code (move_code),
        .move_half (move_half),
        .move_valid(move_valid),
        .move_ready(move_ready),
        .abort     (abort),
        .move_done (move_done),
        .move_err  (move_err),
        .aborted   (aborted),
        .dir_pin   (dir_pin),
        .step_pin  (step_pin),
        .en_pins   (en_pins)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp_v, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (move_done || move_err) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_is_err", int'(move_err), int'(e.is_err));
                check("pulse_is_done", int'(move_done), int'(!e.is_err));
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_aborted", int'(aborted), int'(e.ab));
            end
        end
    end

    // Step waveform monitor
    always @(negedge clk) begin
        if (step_pin && !step_prev) begin
            rises++;
            if (first_rise < 0) first_rise = cyc;
            hi_len = 1;
        end else if (step_pin) begin
            hi_len++;
        end else if (step_prev && !skip_pw) begin
            check("step_high_len", hi_len, 3);
        end
        step_prev = step_pin;
    end

    task automatic wait_cyc(input int t);
        int n = 0;
        while (cyc < t && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!move_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!move_ready) check("ready_wait", 0, 1);
    endtask

    task automatic send(input int code, input bit half, input bit push,
                        input bit is_err, input int off, input bit ab,
                        input bit keep, output int c);
        exp_t e;
        wait_ready();
        move_code  = 4'(code);
        move_half  = half;
        move_valid = 1'b1;
        c          = cyc;
        rises      = 0;
        first_rise = -1;
        if (push) begin
            e.is_err = is_err;
            e.cyc    = c + off;
            e.ab     = ab;
            sb.push_back(e);
        end
        @(negedge clk);
        if (!keep) move_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_codes[3];
        bad_codes = '{0, 1, 14};
        reset_n = 1'b0;
        move_valid = 1'b0;
        move_code = '0;
        move_half = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(move_ready), 0);
        check("rst_en", int'(en_pins), 0);
        check("rst_dir", int'(dir_pin), 0);
        check("rst_step", int'(step_pin), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", int'(move_ready), 1);

        // Quarter turn R', abort held in IDLE (ignored)
        abort = 1'b1;
        repeat (2) @(negedge clk);
        send(Ri, 1'b0, 1'b1, 1'b0, 32, 1'b0, 1'b0, c0);
        abort = 1'b0;
        wait_cyc(c0 + 1);
        check("q_en", int'(en_pins), 1);
        check("q_dir", int'(dir_pin), 1);
        check("q_ready_low", int'(move_ready), 0);
        wait_cyc(c0 + 2);
        check("q_step_setup", int'(step_pin), 0);
        wait_cyc(c0 + 32);
        check("q_en_done", int'(en_pins), 0);
        check("q_ready_done", int'(move_ready), 0);
        wait_cyc(c0 + 33);
        check("q_ready", int'(move_ready), 1);
        check("q_rises", rises, 4);
        check("q_first_rise", first_rise, c0 + 3);
        wait_cyc(c0 + 40);
        check("q_dir_hold", int'(dir_pin), 1);

        // Half turn D
        send(D, 1'b1, 1'b1, 1'b0, 56, 1'b0, 1'b0, c0);
        wait_cyc(c0 + 1);
        check("h_en", int'(en_pins), 32);
        check("h_dir", int'(dir_pin), 0);
        wait_cyc(c0 + 57);
        check("h_rises", rises, 8);
        check("h_ready", int'(move_ready), 1);

        // Abort during the 2nd step high phase
        send(R, 1'b0, 1'b1, 1'b0, 20, 1'b1, 1'b0, c0);
        wait_cyc(c0 + 9);
        check("a_step_hi2", int'(step_pin), 1);
        abort = 1'b1;
        wait_cyc(c0 + 10);
        abort = 1'b0;
        wait_cyc(c0 + 21);
        check("a_rises", rises, 2);
        check("a_ready", int'(move_ready), 1);

        // Abort in SETUP skips all steps
        send(L, 1'b0, 1'b1, 1'b0, 8, 1'b1, 1'b0, c0);
        abort = 1'b1;
        wait_cyc(c0 + 2);
        abort = 1'b0;
        wait_cyc(c0 + 5);
        check("as_en_settle", int'(en_pins), 2);
        wait_cyc(c0 + 9);
        check("as_rises", rises, 0);
        check("as_ready", int'(move_ready), 1);

        // NULL and illegal codes
        send(NULL, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, c0);
        check("null_en", int'(en_pins), 0);
        wait_cyc(c0 + 2);
        check("null_ready", int'(move_ready), 1);
        foreach (bad_codes[i]) begin
            send(bad_codes[i], 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, c0);
            check("err_en", int'(en_pins), 0);
            wait_cyc(c0 + 2);
            check("err_ready", int'(move_ready), 1);
            check("err_rises", rises, 0);
        end

        // Back-to-back R then F with valid held
        send(R, 1'b0, 1'b1, 1'b0, 32, 1'b0, 1'b1, c0);
        move_code = 4'(F);
        sb.push_back('{1'b0, c0 + 65, 1'b0});
        check("bb_en1", int'(en_pins), 1);
        wait_cyc(c0 + 32);
        check("bb_en_done", int'(en_pins), 0);
        check("bb_ready_done", int'(move_ready), 0);
        wait_cyc(c0 + 33);
        check("bb_ready33", int'(move_ready), 1);
        check("bb_en33", int'(en_pins), 0);
        check("bb_dir33", int'(dir_pin), 0);
        wait_cyc(c0 + 34);
        move_valid = 1'b0;
        check("bb_ready34", int'(move_ready), 0);
        check("bb_en34", int'(en_pins), 8);
        check("bb_dir34", int'(dir_pin), 0);
        wait_cyc(c0 + 66);
        check("bb_rises", rises, 8);

        // Reset in the middle of a move
        send(Li, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, c0);
        wait_cyc(c0 + 10);
        skip_pw = 1'b1;
        reset_n = 1'b0;
        wait_cyc(c0 + 11);
        check("mr_en", int'(en_pins), 0);
        check("mr_dir", int'(dir_pin), 0);
        check("mr_step", int'(step_pin), 0);
        check("mr_ready", int'(move_ready), 0);
        check("mr_done", int'(move_done), 0);
        wait_cyc(c0 + 12);
        reset_n = 1'b1;
        check("mr_ready_rst", int'(move_ready), 0);
        wait_cyc(c0 + 13);
        check("mr_ready_back", int'(move_ready), 1);
        wait_cyc(c0 + 45);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stepper_move_engine.md
# stepper_move_engine

Parametrised successor to the fixed quarter-turn move executor. It accepts one cube move at a time over a valid/ready handshake and drives a shared DIR/STEP bus plus one enable line per motor. It generates the step waveform from the system clock with programmable timing, supports quarter and half turns, enforces a DIR-setup delay and a post-move settle dwell, and reports illegal codes. It sits between the move-sequence FIFO (solver output) and the board-level stepper-driver pins.

## Interface
- NUM_MOTORS, 6, motor count; must satisfy NUM_MOTORS ≤ 2^(MOVE_W-1) − 2
- MOVE_W, 4, move-code width
- QUARTER_STEPS, 50, full steps per quarter turn; must be ≥ 1
- STEP_HALF, 500000, clock cycles STEP is held high, and again held low, per step (100 Hz at 100 MHz); must be ≥ 1
- DIR_SETUP, 100, cycles between DIR/enable valid and the first STEP rise; must be ≥ 1
- SETTLE, 1000000, cycles enable is held after the last step; must be ≥ 1
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- move_code  in  MOVE_W  move code: face = move_code[MOVE_W-1:1] − 1, dir = move_code[0]
- move_half  in  1  1 = half turn (2×QUARTER_STEPS steps)
- move_valid  in  1  request
- move_ready  out  1  engine idle, request accepted this cycle if valid
- abort  in  1  stop after the current step completes
- move_done  out  1  one-cycle pulse at end of move
- move_err  out  1  one-cycle pulse, illegal code rejected
- aborted  out  1  qualifies move_done; high if the move was cut short
- dir_pin  out  1  direction to all drivers
- step_pin  out  1  step pulse to all drivers
- en_pins  out  NUM_MOTORS  active-high enable, one-hot or zero

## Operation
- Accept = move_valid & move_ready. Code, half flag, and dir are latched at accept. move_ready drops the next cycle.
- Code classes:
  - All-ones (NULL): no motion. move_done pulses the cycle after accept.
  - Face field in 1..NUM_MOTORS: legal move.
  - Anything else: move_err pulses the cycle after accept. No move_done. No pin activity.
- States:
  - IDLE → SETUP on a legal accept.
  - SETUP: en_pins[face]=1, dir_pin=dir, step_pin=0. Lasts DIR_SETUP cycles, then STEP_HI.
  - STEP_HI: step_pin=1 for STEP_HALF cycles, then STEP_LO.
  - STEP_LO: step_pin=0 for STEP_HALF cycles. Step count increments at the exit of this state. Go to STEP_HI if count < N and abort was not seen; otherwise go to SETTLE.
  - SETTLE: enable is still held, step_pin=0. Lasts SETTLE cycles, then DONE.
  - DONE: move_done=1 and en_pins=0 for one cycle, then IDLE.
- N = QUARTER_STEPS, or 2·QUARTER_STEPS when move_half=1.
- Step counter width is $clog2(2·QUARTER_STEPS+1).
- The timer is one down-counter of width $clog2(max(STEP_HALF, DIR_SETUP, SETTLE)+1).
- Abort is sticky from when it is sampled high in SETUP or any STEP state until DONE. It never truncates a STEP pulse.
  - Abort sampled in SETUP skips all steps and goes straight to SETTLE.
  - aborted=1 with the move_done pulse.
  - Abort in IDLE, SETTLE, or DONE is ignored.
- dir_pin holds its last value in IDLE. It only changes at accept.

## Timing
- Reset values:
  - move_ready=0, returning to 1 the first cycle after reset_n=1.
  - move_done=0, move_err=0, aborted=0, dir_pin=0, step_pin=0, en_pins=0.
  - State = IDLE.
- Reset mid-move: all outputs reach reset values on the next edge. The move is lost and no move_done is issued.
- All outputs are registered. There is no combinational path from inputs to pins.
- Legal move accepted at cycle 0:
  - en/dir valid in cycle 1.
  - First step_pin rise at cycle 1+DIR_SETUP.
  - move_done at cycle T = 1 + DIR_SETUP + 2·N·STEP_HALF + SETTLE.
  - move_ready=1 at cycle T+1. A new accept is possible at T+1.
- NULL or illegal accept at cycle 0: pulse at cycle 1, move_ready=1 at cycle 2.
- move_valid while not ready is ignored. Inputs need not be held after accept.

## Structure
- Shared package rbot_pkg holds:
  - Move-code localparams R..Di (2..13) and NULL (15).
  - Face indices RIGHT..DOWN (0..5).
  - State enum constants.
- One sub-module: cycle_timer.
  - Ports: load, load value, count-down, one-cycle expire pulse.
  - Instantiated once. It is reloaded at each state entry with DIR_SETUP, STEP_HALF, or SETTLE.

## Test plan
All scenarios use DIR_SETUP=2, STEP_HALF=3, QUARTER_STEPS=4, SETTLE=5.
- Quarter turn, code 3 (R′), accept at cycle 0:
  - en_pins=000001 and dir_pin=1 from cycle 1.
  - 4 pulses, each 3 cycles high and 3 low, first rise at cycle 3.
  - move_done at cycle 32, en_pins=0 at cycle 32.
  - move_ready at cycle 33.
- Half turn, code 12 (D) with move_half=1: en_pins=100000, 8 pulses, move_done at cycle 56.
- Abort asserted during the 2nd step's high phase:
  - The 2nd pulse completes fully and there is no 3rd rise.
  - move_done with aborted=1 at cycle 1+2+12+5=20.
- Code 15 → move_done at cycle 1 with no pin activity. Codes 0, 1, 14 → move_err at cycle 1, no move_done, en_pins stays 0.
- Back-to-back:
  - move_valid held high with codes 2 then 8. The second is accepted at cycle 33.
  - dir_pin changes only at cycle 34. en_pins goes 000001 → 0 → 001000.
- reset_n=0 at cycle 10 of a move:
  - All outputs are 0 at cycle 11. No move_done.
  - move_ready=1 the cycle after reset_n returns to 1.
